// File: rtl/yuv_rgb_pkg.sv
// Shared constants, pixel layouts and helpers for the YUV444 -> XRGB converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package yuv_rgb_pkg;

  // Every intermediate result fits in 20 bits signed for any 8-bit Y/U/V.
  localparam int INT_W = 20;
  typedef logic signed [INT_W-1:0] sint_t;

  localparam sint_t COEF_Y  = sint_t'(298);
  localparam sint_t COEF_RV = sint_t'(409);
  localparam sint_t COEF_GU = sint_t'(100);
  localparam sint_t COEF_GV = sint_t'(208);
  localparam sint_t COEF_BU = sint_t'(516);

  localparam sint_t OFF_Y   = sint_t'(16);
  localparam sint_t OFF_C   = sint_t'(128);
  localparam sint_t ROUND   = sint_t'(128);
  localparam int    SHIFT   = 8;

  // One 32-bit lane, MSB first: byte3 pad, byte2 Y, byte1 U, byte0 V.
  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv_pix_t;

  // One 32-bit lane, MSB first: byte3 pad, byte2 R, byte1 G, byte0 B.
  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pix_t;

  // Zero-extend an unsigned byte into the signed intermediate width.
  function automatic sint_t zext8(input logic [7:0] b);
    return sint_t'({{(INT_W-8){1'b0}}, b});
  endfunction

  // Arithmetic shift (floor) then clamp to 0..255.
  function automatic logic [7:0] sat8(input sint_t sum);
    sint_t q;
    q = sum >>> SHIFT;
    if (q[INT_W-1]) begin
      return 8'h00;
    end else if (|q[INT_W-2:8]) begin
      return 8'hFF;
    end
    return q[7:0];
  endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// Stream channel bundle: valid/ready handshake with data, byte qualifiers and sideband.
// Latency: n/a (wires only).
// Backpressure: master holds payload while t_valid && !t_ready.
interface nasti_stream_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 64
);
  logic                    t_valid;
  logic                    t_ready;
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic                    t_last;
  logic [ID_WIDTH-1:0]     t_id;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [USER_WIDTH-1:0]   t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/yuv2rgb_pixel.sv
// Converts one YUV444 pixel to XRGB: products, then rounded sums, then shift+saturate.
// Latency: 3 registered stages; the last stage is the output register.
// Backpressure: all stages hold while en is low.
module yuv2rgb_pixel
  import yuv_rgb_pkg::*;
(
  input  logic     aclk,
  input  logic     aresetn,
  input  logic     en,
  input  yuv_pix_t pix_in,
  output rgb_pix_t pix_out
);

  sint_t c, d, e;
  sint_t p_y, p_rv, p_gu, p_gv, p_bu;
  sint_t s_r, s_g, s_b;
  logic  unused_pad;

  // Input byte3 carries no colour information.
  assign unused_pad = ^pix_in.pad;

  assign c = zext8(pix_in.y) - OFF_Y;
  assign d = zext8(pix_in.u) - OFF_C;
  assign e = zext8(pix_in.v) - OFF_C;

  // Stage 1: register the five coefficient products.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      p_y  <= '0;
      p_rv <= '0;
      p_gu <= '0;
      p_gv <= '0;
      p_bu <= '0;
    end else if (en) begin
      p_y  <= COEF_Y  * c;
      p_rv <= COEF_RV * e;
      p_gu <= COEF_GU * d;
      p_gv <= COEF_GV * e;
      p_bu <= COEF_BU * d;
    end
  end

  // Stage 2: per-channel sums with the rounding constant folded in.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_r <= '0;
      s_g <= '0;
      s_b <= '0;
    end else if (en) begin
      s_r <= p_y + p_rv + ROUND;
      s_g <= p_y - p_gu - p_gv + ROUND;
      s_b <= p_y + p_bu + ROUND;
    end
  end

  // Stage 3: floor shift and clamp into the output register; pad byte forced to zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_out <= '0;
    end else if (en) begin
      pix_out <= rgb_pix_t'({8'h00, sat8(s_r), sat8(s_g), sat8(s_b)});
    end
  end

endmodule

// File: rtl/yuv444_to_rgb.sv
// Two-pixel-per-beat YUV444 -> XRGB stream converter with sideband passthrough.
// Latency: 3 cycles from src handshake to dst.t_valid; one beat per cycle sustained.
// Backpressure: single enable stalls every stage; src.t_ready = !dst.t_valid || dst.t_ready.
module yuv444_to_rgb
  import yuv_rgb_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  nasti_stream_channel.slave        src,
  nasti_stream_channel.master       dst
);

  typedef struct packed {
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [DEST_WIDTH-1:0] dest;
    logic [ID_WIDTH-1:0]   id;
  } side_t;

  logic     en;
  logic     vld_s1, vld_s2, vld_out;
  side_t    side_in, side_s1, side_s2, side_out;
  rgb_pix_t rgb0, rgb1;

  // Output register empty or draining: the whole pipe may move.
  assign en          = !vld_out || dst.t_ready;
  assign src.t_ready = en;

  assign side_in = '{last: src.t_last, user: src.t_user, dest: src.t_dest, id: src.t_id};

  yuv2rgb_pixel u_pix0 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (en),
    .pix_in  (yuv_pix_t'(src.t_data[31:0])),
    .pix_out (rgb0)
  );

  yuv2rgb_pixel u_pix1 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (en),
    .pix_in  (yuv_pix_t'(src.t_data[63:32])),
    .pix_out (rgb1)
  );

  // Valid bits and sideband travel in lockstep with the pixel stages; bubbles move too.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_s1   <= 1'b0;
      vld_s2   <= 1'b0;
      vld_out  <= 1'b0;
      side_s1  <= '0;
      side_s2  <= '0;
      side_out <= '0;
    end else if (en) begin
      vld_s1   <= src.t_valid;
      vld_s2   <= vld_s1;
      vld_out  <= vld_s2;
      side_s1  <= side_in;
      side_s2  <= side_s1;
      side_out <= side_s2;
    end
  end

  assign dst.t_valid = vld_out;
  assign dst.t_data  = {rgb1, rgb0};
  assign dst.t_strb  = '1;
  assign dst.t_keep  = '1;
  assign dst.t_last  = side_out.last;
  assign dst.t_user  = side_out.user;
  assign dst.t_dest  = side_out.dest;
  assign dst.t_id    = side_out.id;

  // Partial lanes have no meaning for pixel data, so flag any accepted beat carrying them.
  always @(posedge aclk) begin
    if (aresetn && src.t_valid && en) begin
      assert (&src.t_keep && &src.t_strb) else $error("Null byte not supported");
    end
  end

endmodule

// File: tb/tb_yuv444_to_rgb.sv
// Directed bench for yuv444_to_rgb: reset, latency, colour vectors, backpressure, reset mid-stream.
// Latency: checks the 3-cycle handshake-to-valid path.
// Backpressure: drives dst.t_ready stall windows and checks hold/order.
module tb_yuv444_to_rgb;

  // Input lanes and hand-computed XRGB results.
  localparam logic [31:0] L_BLACK = 32'h00108080, E_BLACK = 32'h00000000;
  localparam logic [31:0] L_WHITE = 32'h00EB8080, E_WHITE = 32'h00FFFFFF;
  localparam logic [31:0] L_Y255  = 32'h00FF8080, E_Y255  = 32'h00FFFFFF;
  localparam logic [31:0] L_Y0    = 32'h00008080, E_Y0    = 32'h00000000;
  localparam logic [31:0] L_RED   = 32'hAA515AF0, E_RED   = 32'h00FF0000;
  localparam logic [31:0] L_GREY  = 32'h00808080, E_GREY  = 32'h00828282;
  localparam logic [31:0] L_A     = 32'h006432C8, E_A     = 32'h00D54600;
  localparam logic [31:0] L_B     = 32'h0096C83C, E_B     = 32'h002FB7FF;

  logic aclk = 1'b0;
  logic aresetn;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] in_dat  [8];
  logic [63:0] exp_dat [8];
  logic [3:0]  in_user [8];
  logic [2:0]  in_dest [8];
  logic [1:0]  in_id   [8];
  logic        in_last [8];

  always #5 aclk = ~aclk;

  nasti_stream_channel #(.ID_WIDTH(2), .DEST_WIDTH(3), .USER_WIDTH(4), .DATA_WIDTH(64)) src_if ();
  nasti_stream_channel #(.ID_WIDTH(2), .DEST_WIDTH(3), .USER_WIDTH(4), .DATA_WIDTH(64)) dst_if ();

  yuv444_to_rgb #(
    .DATA_WIDTH (64),
    .USER_WIDTH (4),
    .DEST_WIDTH (3),
    .ID_WIDTH   (2)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .src     (src_if),
    .dst     (dst_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_beat(input int i);
    src_if.t_data = in_dat[i];
    src_if.t_user = in_user[i];
    src_if.t_dest = in_dest[i];
    src_if.t_id   = in_id[i];
    src_if.t_last = in_last[i];
  endtask

  // Streams beats first..first+n-1; dst.t_ready is low in cycles whose stall bit is set.
  task automatic run_beats(input int first, input int n, input logic [63:0] stall);
    int          sent;
    int          got;
    logic        held_v;
    logic [63:0] held_d;
    logic [9:0]  held_s;
    sent   = 0;
    got    = 0;
    held_v = 1'b0;
    held_d = '0;
    held_s = '0;
    for (int c = 0; c < 300 && got < n; c++) begin
      if (sent < n) begin
        drive_beat(first + sent);
        src_if.t_valid = 1'b1;
      end else begin
        src_if.t_valid = 1'b0;
      end
      dst_if.t_ready = (c < 64) ? !stall[c] : 1'b1;
      #1;
      if (held_v) begin
        chk("hold_data", dst_if.t_data, held_d);
        chk("hold_side", {dst_if.t_last, dst_if.t_user, dst_if.t_dest, dst_if.t_id}, held_s);
      end
      if (dst_if.t_valid && !dst_if.t_ready) chk("src_ready_stalled", src_if.t_ready, 1'b0);
      if (dst_if.t_valid && dst_if.t_ready) begin
        chk("out_data", dst_if.t_data, exp_dat[first + got]);
        chk("out_user", dst_if.t_user, in_user[first + got]);
        chk("out_dest", dst_if.t_dest, in_dest[first + got]);
        chk("out_id",   dst_if.t_id,   in_id[first + got]);
        chk("out_last", dst_if.t_last, in_last[first + got]);
        got++;
      end
      held_v = dst_if.t_valid && !dst_if.t_ready;
      held_d = dst_if.t_data;
      held_s = {dst_if.t_last, dst_if.t_user, dst_if.t_dest, dst_if.t_id};
      if (src_if.t_valid && src_if.t_ready) sent++;
      tick();
    end
    src_if.t_valid = 1'b0;
    chk("beat_count", got, n);
  endtask

  initial begin
    // Beat table: {lane1, lane0}.
    in_dat[0] = {L_WHITE, L_BLACK}; exp_dat[0] = {E_WHITE, E_BLACK};
    in_dat[1] = {L_Y255,  L_Y0};    exp_dat[1] = {E_Y255,  E_Y0};
    in_dat[2] = {L_RED,   L_GREY};  exp_dat[2] = {E_RED,   E_GREY};
    in_dat[3] = {L_A,     L_B};     exp_dat[3] = {E_A,     E_B};
    in_dat[4] = {L_B,     L_RED};   exp_dat[4] = {E_B,     E_RED};
    in_dat[5] = {L_GREY,  L_WHITE}; exp_dat[5] = {E_GREY,  E_WHITE};
    in_dat[6] = {L_Y0,    L_A};     exp_dat[6] = {E_Y0,    E_A};
    in_dat[7] = {L_BLACK, L_Y255};  exp_dat[7] = {E_BLACK, E_Y255};
    for (int i = 0; i < 8; i++) begin
      in_user[i] = 4'(i + 1);
      in_dest[i] = 3'(7 - i);
      in_id[i]   = 2'(i);
      in_last[i] = (i == 7);
    end

    // Reset state.
    aresetn        = 1'b0;
    src_if.t_valid = 1'b0;
    src_if.t_data  = '0;
    src_if.t_strb  = '1;
    src_if.t_keep  = '1;
    src_if.t_last  = 1'b0;
    src_if.t_user  = '0;
    src_if.t_dest  = '0;
    src_if.t_id    = '0;
    dst_if.t_ready = 1'b0;
    #12;
    chk("rst_valid", dst_if.t_valid, 1'b0);
    chk("rst_data",  dst_if.t_data,  64'h0);
    chk("rst_last",  dst_if.t_last,  1'b0);
    chk("rst_user",  dst_if.t_user,  4'h0);
    chk("rst_dest",  dst_if.t_dest,  3'h0);
    chk("rst_id",    dst_if.t_id,    2'h0);
    chk("rst_strb",  {dst_if.t_strb, dst_if.t_keep}, 16'hFFFF);
    tick();
    aresetn = 1'b1;
    tick();
    chk("post_rst_src_ready", src_if.t_ready, 1'b1);

    // Latency: single black beat, valid exactly 3 cycles after the handshake.
    dst_if.t_ready = 1'b1;
    src_if.t_data  = {L_BLACK, L_BLACK};
    src_if.t_user  = 4'h5;
    src_if.t_dest  = 3'h2;
    src_if.t_id    = 2'h3;
    src_if.t_last  = 1'b1;
    src_if.t_valid = 1'b1;
    tick();
    src_if.t_valid = 1'b0;
    chk("lat_c1_valid", dst_if.t_valid, 1'b0);
    tick();
    chk("lat_c2_valid", dst_if.t_valid, 1'b0);
    tick();
    chk("lat_c3_valid", dst_if.t_valid, 1'b1);
    chk("lat_black",    dst_if.t_data,  64'h0);
    chk("lat_user",     dst_if.t_user,  4'h5);
    chk("lat_dest",     dst_if.t_dest,  3'h2);
    chk("lat_id",       dst_if.t_id,    2'h3);
    chk("lat_last",     dst_if.t_last,  1'b1);
    tick();
    chk("lat_c4_valid", dst_if.t_valid, 1'b0);

    // Full-rate stream of colour vectors with varied sideband.
    run_beats(0, 8, 64'h0);

    // Same stream with dst.t_ready low in cycles 4..8.
    run_beats(0, 8, 64'h1F0);

    // Reset with three beats in flight.
    dst_if.t_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(i);
      src_if.t_valid = 1'b1;
      tick();
    end
    src_if.t_valid = 1'b0;
    chk("pre_rst_valid", dst_if.t_valid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_valid", dst_if.t_valid, 1'b0);
    chk("mid_rst_data",  dst_if.t_data,  64'h0);
    chk("mid_rst_user",  dst_if.t_user,  4'h0);
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_valid", dst_if.t_valid, 1'b0);
    end
    run_beats(3, 2, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yuv444_to_rgb.md
YUV444_TO_RGB -- requirements
Module: yuv444_to_rgb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64; stream data width, fixed at two 32-bit pixels per beat.
REQ-002 SHALL have parameter USER_WIDTH, default 1; t_user width.
REQ-003 SHALL have parameter DEST_WIDTH, default 1; t_dest width.
REQ-004 SHALL have port aclk, input, 1 bit; the single clock, all logic on rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit; reset, asynchronous, active-low.
REQ-006 SHALL have port src, nasti_stream_channel.slave, DATA_WIDTH; packed YUV444 in: per 32-bit lane, byte0 V, byte1 U, byte2 Y, byte3 ignored.
REQ-007 SHALL have port dst, nasti_stream_channel.master, DATA_WIDTH; packed XRGB out: per 32-bit lane, byte0 B, byte1 G, byte2 R, byte3 0x00.

Function
REQ-008 SHALL convert lane 0 (bits 31:0) and lane 1 (bits 63:32) independently and identically.
REQ-009 SHALL compute, signed: C = Y-16, D = U-128, E = V-128.
REQ-010 SHALL compute R = (298C + 409E + 128) >>> 8, G = (298C - 100D - 208E + 128) >>> 8, B = (298C + 516D + 128) >>> 8; arithmetic shift, floor.
REQ-011 SHALL hold all intermediates in at least 20-bit signed; no overflow for any 8-bit input.
REQ-012 SHALL saturate each result: <0 -> 0x00, >255 -> 0xFF, else low 8 bits.
REQ-013 SHALL be a 3-stage pipeline: S1 offsets + products, S2 sums + rounding, S3 shift + saturate into dst registers; latency exactly 3 cycles from src handshake to dst.t_valid when unstalled.
REQ-014 SHALL use one pipeline enable en = !dst.t_valid || dst.t_ready; src.t_ready = en; no stage advances when en = 0.
REQ-015 SHALL carry a valid bit per stage; bubbles advance under en like data; src beat captured only when src.t_valid && en.
REQ-016 SHALL sustain one beat per cycle with dst.t_ready held high.
REQ-017 SHALL keep dst.t_data, t_last, t_user, t_dest, t_id stable while dst.t_valid && !dst.t_ready.
REQ-018 SHALL pass t_last, t_user, t_dest, t_id through delayed in lockstep with their beat.
REQ-019 SHALL drive dst.t_strb and dst.t_keep to all ones.
REQ-020 SHALL assert (simulation only) that every accepted src beat has t_keep and t_strb all ones; error "Null byte not supported".
REQ-021 SHALL preserve beat order; no beat dropped or duplicated under any backpressure pattern.

Reset
REQ-022 SHALL on aresetn low, asynchronously clear all stage valid bits and dst.t_valid.
REQ-023 SHALL reset dst.t_data, t_last, t_user, t_dest, t_id to 0.
REQ-024 SHALL discard beats in flight at reset mid-stream; first post-reset output is first beat accepted after reset release.
REQ-025 SHALL hold src.t_ready high (en = 1) immediately after reset, since dst.t_valid = 0.

Structure
REQ-026 SHALL place coefficients (298, 409, 100, 208, 516), offsets (16, 128), rounding constant 128, shift 8, and intermediate width in shared package yuv_rgb_pkg.
REQ-027 SHALL place a packed pixel struct (v, u, y, pad / b, g, r, pad bytes) in yuv_rgb_pkg.
REQ-028 SHALL implement the per-pixel datapath as sub-module yuv2rgb_pixel (3 registered stages, enable input), instantiated twice; sideband and valid pipeline in the top.

Verification
REQ-029 SHALL cover black: both lanes 0x00108080 (Y16 U128 V128) -> dst.t_data 0x0000000000000000 after 3 cycles.
REQ-030 SHALL cover white: lane 0x00EB8080 (Y235) -> 0x00FFFFFF; Y=255 U=V=128 -> 0x00FFFFFF (upper saturate); Y=0 U=V=128 -> 0x00000000 (lower saturate).
REQ-031 SHALL cover red: Y81 U90 V240 (lane 0x0051 5AF0) -> 0x00FF0000 (R255, G0, B0); byte3 of input 0xAA -> output byte3 still 0x00.
REQ-032 SHALL cover backpressure: 8 back-to-back beats, dst.t_ready low cycles 4-8 -> src.t_ready low while stalled, dst payload stable, all 8 beats out in order, t_last only on beat 8.
REQ-033 SHALL cover sideband: t_user/t_dest/t_id varied per beat -> each emerges with its own beat's pixels.
REQ-034 SHALL cover reset mid-stream: aresetn low with 3 beats in flight -> dst.t_valid 0 immediately, no stale beat emitted after release.
